// File: rtl/fib_inst_seq_pkg.sv
// Shared types and MIPS encoding constants for the Fibonacci instruction sequencer.
// The STORE state exists only when FIB_SEQ_STORE_EN is defined.
package fib_inst_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_A,
    S_INIT_B,
    S_LOOP,
`ifdef FIB_SEQ_STORE_EN
    S_STORE,
`endif
    S_DONE
  } state_t;

  typedef enum logic {
    FMT_R,
    FMT_I
  } inst_fmt_t;

  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [4:0] REG_ZERO  = 5'd0;

endpackage

// File: rtl/fib_inst_seq_if.sv
// Instruction valid/ready channel between the sequencer (master) and the CPU (slave).
interface fib_inst_seq_if;

  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready;

  modport master (
    output inst,
    output inst_valid,
    input  inst_ready
  );

  modport slave (
    input  inst,
    input  inst_valid,
    output inst_ready
  );

endinterface

// File: rtl/fib_inst_seq_enc.sv
// Combinational MIPS word builder for R-type and I-type formats.
module mips_inst_enc
  import fib_inst_seq_pkg::*;
(
  input  inst_fmt_t   fmt,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = '0;
    case (fmt)
      FMT_R:   word = {opcode, rs, rt, rd, shamt, funct};
      default: word = {opcode, rs, rt, imm};
    endcase
  end

endmodule

// File: rtl/fib_inst_seq.sv
// Issues addi/addi then a run of alternating adds computing Fibonacci terms in REG_A/REG_B.
// Optional feature: define FIB_SEQ_STORE_EN to append a sw of the last-written register.
module fib_inst_seq
  import fib_inst_seq_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter logic [4:0]  REG_A      = 5'd1,
  parameter logic [4:0]  REG_B      = 5'd2,
  parameter logic [15:0] STORE_ADDR = 16'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  fib_inst_seq_if.master   ibus,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

`ifdef FIB_SEQ_STORE_EN
  localparam state_t LOOP_EXIT = S_STORE;
`else
  localparam state_t LOOP_EXIT = S_DONE;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  inst_fmt_t   enc_fmt;
  logic [5:0]  enc_op;
  logic [4:0]  enc_rs;
  logic [4:0]  enc_rt;
  logic [4:0]  enc_rd;
  logic [5:0]  enc_funct;
  logic [15:0] enc_imm;
  logic [31:0] enc_word;
  logic        valid;

  // Saturating so an all-ones count still terminates on equality.
  assign cnt_inc = (issued_cnt == '1) ? issued_cnt : issued_cnt + CNT_ONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      issued_cnt <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      issued_cnt <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    cnt_d     = issued_cnt;
    valid     = 1'b0;
    enc_fmt   = FMT_I;
    enc_op    = OP_ADDI;
    enc_rs    = REG_ZERO;
    enc_rt    = REG_A;
    enc_rd    = REG_ZERO;
    enc_funct = FUNCT_ADD;
    enc_imm   = STORE_ADDR;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT_A;
          count_d = n_terms;
          cnt_d   = '0;
        end
      end
      S_INIT_A: begin
        valid   = 1'b1;
        enc_rt  = REG_A;
        enc_imm = 16'd1;
        if (ibus.inst_ready) state_d = S_INIT_B;
      end
      S_INIT_B: begin
        valid   = 1'b1;
        enc_rt  = REG_B;
        enc_imm = 16'd1;
        if (ibus.inst_ready) state_d = (count_q == '0) ? LOOP_EXIT : S_LOOP;
      end
      S_LOOP: begin
        valid   = 1'b1;
        enc_fmt = FMT_R;
        enc_op  = OP_RTYPE;
        enc_rs  = REG_A;
        enc_rt  = REG_B;
        enc_rd  = issued_cnt[0] ? REG_B : REG_A;
        if (ibus.inst_ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == count_q) state_d = LOOP_EXIT;
        end
      end
`ifdef FIB_SEQ_STORE_EN
      S_STORE: begin
        // The final add targets REG_A after an odd count, REG_B otherwise.
        valid  = 1'b1;
        enc_op = OP_SW;
        enc_rt = count_q[0] ? REG_A : REG_B;
        if (ibus.inst_ready) state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  mips_inst_enc u_enc (
    .fmt    (enc_fmt),
    .opcode (enc_op),
    .rs     (enc_rs),
    .rt     (enc_rt),
    .rd     (enc_rd),
    .shamt  (5'd0),
    .funct  (enc_funct),
    .imm    (enc_imm),
    .word   (enc_word)
  );

  assign ibus.inst       = valid ? enc_word : '0;
  assign ibus.inst_valid = valid;
  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);

endmodule

// File: tb/tb_fib_inst_seq.sv
// Scoreboard bench: stimulus pushes expected words, a negedge monitor pops on each handshake/done.
module tb_fib_inst_seq;

  localparam int CNT_W = 8;

  localparam logic [31:0] ADDI_A = 32'h20010001;
  localparam logic [31:0] ADDI_B = 32'h20020001;
  localparam logic [31:0] ADD_A  = 32'h00220820;
  localparam logic [31:0] ADD_B  = 32'h00221020;
  localparam logic [31:0] SW_A   = 32'hAC010000;
  localparam logic [31:0] SW_B   = 32'hAC020000;
  localparam logic [32:0] DONE_MARK = 33'h1_0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] issued_cnt;

  fib_inst_seq_if ibus ();

  fib_inst_seq #(
    .CNT_W      (CNT_W),
    .REG_A      (5'd1),
    .REG_B      (5'd2),
    .STORE_ADDR (16'h0000)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .n_terms    (n_terms),
    .ibus       (ibus),
    .busy       (busy),
    .done       (done),
    .issued_cnt (issued_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_seq(input int n);
    exp_q.push_back({1'b0, ADDI_A});
    exp_q.push_back({1'b0, ADDI_B});
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b0, (i % 2 == 1) ? ADD_B : ADD_A});
`ifdef FIB_SEQ_STORE_EN
    exp_q.push_back({1'b0, (n % 2 == 1) ? SW_A : SW_B});
`endif
    exp_q.push_back(DONE_MARK);
  endtask

  // Called at posedge+1 with the DUT idle; returns one cycle later in INIT_A.
  task automatic do_start(input logic [CNT_W-1:0] n);
    start   = 1'b1;
    n_terms = n;
    @(posedge clk); #1;
    start   = 1'b0;
    n_terms = CNT_W'($urandom);
  endtask

  task automatic wait_done(input int limit);
    int k = 0;
    while (done !== 1'b1 && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    if (done !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", limit);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ibus.inst_valid && ibus.inst_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_inst: got 0x%08h expected none", ibus.inst);
        end else begin
          check("inst", {1'b0, ibus.inst}, exp_q.pop_front());
        end
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done expected none");
        end else begin
          check("done_event", DONE_MARK, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1;
    start = 1'b0;
    n_terms = '0;
    ibus.inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_inst", 33'(ibus.inst), 33'h0);
    check("rst_valid", 33'(ibus.inst_valid), 33'h0);
    check("rst_busy", 33'(busy), 33'h0);
    check("rst_done", 33'(done), 33'h0);
    check("rst_cnt", 33'(issued_cnt), 33'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic run, n=3
    push_seq(3);
    do_start(8'd3);
    wait_done(50);
    check("n3_cnt", 33'(issued_cnt), 33'd3);
    check("n3_busy_in_done", 33'(busy), 33'h1);
    @(posedge clk); #1;
    check("n3_busy_idle", 33'(busy), 33'h0);
    check("n3_done_low", 33'(done), 33'h0);

    // Backpressure on the first add
    push_seq(2);
    do_start(8'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    ibus.inst_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("stall_inst", 33'(ibus.inst), 33'(ADD_A));
      check("stall_cnt", 33'(issued_cnt), 33'h0);
    end
    @(posedge clk); #1;
    ibus.inst_ready = 1'b1;
    wait_done(50);
    check("stall_final_cnt", 33'(issued_cnt), 33'd2);
    @(posedge clk); #1;

    // Zero count
    push_seq(0);
    do_start(8'd0);
    wait_done(50);
    check("n0_cnt", 33'(issued_cnt), 33'd0);
    @(posedge clk); #1;

    // Even count
    push_seq(4);
    do_start(8'd4);
    wait_done(50);
    check("n4_cnt", 33'(issued_cnt), 33'd4);
    @(posedge clk); #1;

    // All-ones count
    push_seq(255);
    do_start(8'hFF);
    wait_done(400);
    check("n255_cnt", 33'(issued_cnt), 33'd255);
    @(posedge clk); #1;

    // Reset mid-sequence after the second add
    push_seq(5);
    do_start(8'd5);
    k = 0;
    while (issued_cnt !== 8'd2 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_reach_cnt2", 33'(issued_cnt), 33'd2);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_inst", 33'(ibus.inst), 33'h0);
    check("mid_rst_valid", 33'(ibus.inst_valid), 33'h0);
    check("mid_rst_busy", 33'(busy), 33'h0);
    check("mid_rst_cnt", 33'(issued_cnt), 33'h0);
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_idle", 33'(busy), 33'h0);
    push_seq(1);
    do_start(8'd1);
    wait_done(50);
    check("restart_cnt", 33'(issued_cnt), 33'd1);
    @(posedge clk); #1;

    // start pulses mid-LOOP and during DONE are ignored
    push_seq(6);
    do_start(8'd6);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    n_terms = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(50);
    check("ign_cnt", 33'(issued_cnt), 33'd6);
    start = 1'b1;
    n_terms = 8'd1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_done_start", 33'(busy), 33'h0);
    repeat (5) @(posedge clk);
    #1;
    check("ign_still_idle", 33'(busy), 33'h0);
    check("ign_cnt_kept", 33'(issued_cnt), 33'd6);
    check("queue_drained", 33'(exp_q.size()), 33'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fib_inst_seq.md
FIB_INST_SEQ -- requirements
Module: fib_inst_seq

Interface
REQ-001 Parameter CNT_W, default 8: width of the term-count input and the issued counter.
REQ-002 Parameter REG_A, default 1: first accumulator register number, 5 bits.
REQ-003 Parameter REG_B, default 2: second accumulator register number, 5 bits, must differ from REG_A.
REQ-004 Parameter STORE_ADDR, default 0: 16-bit sw offset, used only with the store feature.
REQ-005 Port clk  in  1: single clock; all state on rising edge.
REQ-006 Port reset  in  1: asynchronous, active-high reset.
REQ-007 Port start  in  1: request to begin a sequence; sampled only in IDLE.
REQ-008 Port n_terms  in  CNT_W: number of add iterations; latched when start is accepted.
REQ-009 Port inst_ready  in  1: CPU accepts inst this cycle.
REQ-010 Port inst  out  32: MIPS instruction word.
REQ-011 Port inst_valid  out  1: inst holds a valid instruction.
REQ-012 Port busy  out  1: high from start acceptance until DONE exits.
REQ-013 Port done  out  1: one-cycle pulse when the sequence completes.
REQ-014 Port issued_cnt  out  CNT_W: add instructions accepted so far in the current sequence.

Function
REQ-015 FSM states: IDLE, INIT_A, INIT_B, LOOP, STORE (macro only), DONE.
REQ-016 IDLE: start=1 latches n_terms, clears issued_cnt, goes to INIT_A next cycle.
REQ-017 INIT_A issues addi REG_A,$0,1; INIT_B issues addi REG_B,$0,1.
REQ-018 LOOP iteration i issues add rd,REG_A,REG_B (funct 100000, shamt 0); rd=REG_A for even i, REG_B for odd i.
REQ-019 A state advances only on the inst_valid && inst_ready handshake; no instruction is ever dropped or duplicated.
REQ-020 While inst_valid=1 and inst_ready=0, inst is held stable.
REQ-021 inst_valid is 1 in INIT_A, INIT_B, LOOP and STORE, and 0 in IDLE and DONE; inst is 0 whenever inst_valid=0.
REQ-022 issued_cnt increments on each accepted add; LOOP exits when issued_cnt reaches the latched count.
REQ-023 Latched count 0: go from INIT_B directly to STORE or DONE.
REQ-024 issued_cnt saturates at 2^CNT_W-1; n_terms=all-ones completes normally without wrap.
REQ-025 DONE lasts exactly one cycle with done=1, then returns to IDLE; busy=0 in IDLE.
REQ-026 start while busy is ignored; n_terms changes after acceptance have no effect.
REQ-027 start asserted in the DONE cycle is ignored; it is accepted only from IDLE.

Reset
REQ-028 reset forces IDLE with inst=0, inst_valid=0, busy=0, done=0, issued_cnt=0, and clears the latched count, asynchronously.
REQ-029 reset mid-sequence abandons the sequence; no further instruction is issued until a new start.

Configuration
REQ-030 Macro FIB_SEQ_STORE_EN defined: after LOOP, STORE issues sw src,STORE_ADDR($0) (opcode 101011, rs=0).
REQ-031 src is the register last written by an add: REG_A if the count is odd, REG_B if the count is even (REG_B when the count is 0).
REQ-032 Macro FIB_SEQ_STORE_EN absent: the STORE state and its logic are not compiled, and LOOP or INIT_B goes straight to DONE.

Structure
REQ-033 A shared package holds the FSM state enum and the opcode/funct constants (ADDI=001000, RTYPE=000000, SW=101011, FUNCT_ADD=100000).
REQ-034 One sub-module, mips_inst_enc, is combinational: it builds R-type and I-type words from fields and is reused by other stimulus blocks.

Verification
REQ-035 Defaults, start with n_terms=3, ready=1 -> 0x20010001, 0x20020001, 0x00220820, 0x00221020, 0x00220820, then done on the next cycle.
REQ-036 ready=0 for 4 cycles during the first add -> inst holds 0x00220820 and issued_cnt holds 0; it advances only after ready rises.
REQ-037 n_terms=0 -> only the two addi words, then done; with FIB_SEQ_STORE_EN, 0xAC020000 is issued before done.
REQ-038 n_terms=3 with FIB_SEQ_STORE_EN -> the last word is 0xAC010000; n_terms=4 -> the last word is 0xAC020000.
REQ-039 reset asserted after the second add is accepted -> outputs are immediately zero; a new start with n_terms=1 restarts at 0x20010001.
REQ-040 start pulsed mid-LOOP and in the DONE cycle -> ignored, with no extra sequence and issued_cnt unaffected.
